// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: serve/play/miss sequencing with frame-tick motion.
// Define PONG_PADDLE_EN to enable left-paddle hit/miss detection.
module pong_ball_ctrl #(
    parameter int DISPLAY_WIDTH  = 256,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int BALL_SIZE      = 4,
    parameter int SERVE_FRAMES   = 60,
    parameter int PADDLE_H       = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       serve,
    input  logic [8:0] paddle_vpos,
    output logic [8:0] ball_hpos,
    output logic [8:0] ball_vpos,
    output logic [1:0] state,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        MISS  = 2'd3
    } state_t;

    localparam int          CW    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [8:0]  CX    = 9'(DISPLAY_WIDTH / 2);
    localparam logic [8:0]  CY    = 9'(DISPLAY_HEIGHT / 2);
    localparam logic [8:0]  X_MAX = 9'(DISPLAY_WIDTH - BALL_SIZE);
    localparam logic [8:0]  Y_MAX = 9'(DISPLAY_HEIGHT - BALL_SIZE);

    state_t        st_q, st_d;
    logic          vsync_q;
    logic          frame_tick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    hpos_q, hpos_d;
    logic [8:0]    vpos_q, vpos_d;
    logic          hdir_q, hdir_d;
    logic          vdir_q, vdir_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic [7:0]    score_q, score_d;
    logic [9:0]    h_up, v_up;
    logic          left_edge;
    logic          paddle_ok;

    assign frame_tick = vsync & ~vsync_q;
    assign h_up       = {1'b0, hpos_q} + 10'd2;
    assign v_up       = {1'b0, vpos_q} + 10'd2;
    assign left_edge  = !hdir_q && (hpos_q <= 9'd1);

`ifdef PONG_PADDLE_EN
    logic [9:0] ball_bot, pad_bot;
    assign ball_bot  = {1'b0, vpos_q} + 10'(BALL_SIZE);
    assign pad_bot   = {1'b0, paddle_vpos} + 10'(PADDLE_H);
    assign paddle_ok = (ball_bot > {1'b0, paddle_vpos})
                    && ({1'b0, vpos_q} < pad_bot);
`else
    localparam int unused_paddle_h = PADDLE_H;
    logic unused_paddle;
    assign unused_paddle = ^paddle_vpos;
    assign paddle_ok     = 1'b1;
`endif

    // Direction bits: 1 = positive (right/down), 0 = negative (left/up)
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hdir_d  = hdir_q;
        vdir_d  = vdir_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        unique case (st_q)
            IDLE: begin
                if (serve) begin
                    st_d  = SERVE;
                    cnt_d = '0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == LAST) begin
                        st_d  = PLAY;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PLAY: begin
                if (frame_tick && left_edge && !paddle_ok) begin
                    miss_d  = 1'b1;
                    score_d = score_q + 8'd1;
                    st_d    = MISS;
                end else if (frame_tick) begin
                    if (hdir_q) begin
                        if (h_up > {1'b0, X_MAX}) begin
                            hpos_d = X_MAX;
                            hdir_d = 1'b0;
                            hit_d  = 1'b1;
                        end else begin
                            hpos_d = h_up[8:0];
                        end
                    end else if (left_edge) begin
                        hpos_d = '0;
                        hdir_d = 1'b1;
                        hit_d  = 1'b1;
                    end else begin
                        hpos_d = hpos_q - 9'd2;
                    end
                    if (vdir_q) begin
                        if (v_up > {1'b0, Y_MAX}) begin
                            vpos_d = Y_MAX;
                            vdir_d = 1'b0;
                            hit_d  = 1'b1;
                        end else begin
                            vpos_d = v_up[8:0];
                        end
                    end else if (vpos_q <= 9'd1) begin
                        vpos_d = '0;
                        vdir_d = 1'b1;
                        hit_d  = 1'b1;
                    end else begin
                        vpos_d = vpos_q - 9'd2;
                    end
                end
            end
            MISS: begin
                if (frame_tick) begin
                    st_d   = SERVE;
                    cnt_d  = '0;
                    hpos_d = CX;
                    vpos_d = CY;
                    hdir_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            st_q    <= IDLE;
            cnt_q   <= '0;
            hpos_q  <= CX;
            vpos_q  <= CY;
            hdir_q  <= 1'b0;
            vdir_q  <= 1'b1;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
        end else begin
            vsync_q <= vsync;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hdir_q  <= hdir_d;
            vdir_q  <= vdir_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
        end
    end

    assign ball_hpos = hpos_q;
    assign ball_vpos = vpos_q;
    assign state     = st_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Self-checking bench for pong_ball_ctrl against a frame-level model.
// Honours PONG_PADDLE_EN the same way as the design.
module tb_pong_ball_ctrl;

    localparam int XMAX = 252;
    localparam int YMAX = 236;
    localparam int CX   = 128;
    localparam int CY   = 120;
    localparam int SF   = 60;
`ifdef PONG_PADDLE_EN
    localparam bit PADDLE_EN = 1'b1;
`else
    localparam bit PADDLE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vsync = 1'b0;
    logic       serve = 1'b0;
    logic [8:0] paddle_vpos = 9'd0;
    logic [8:0] ball_hpos, ball_vpos;
    logic [1:0] state;
    logic       hit, miss;
    logic [7:0] score;

    int total = 0;
    int bad = 0;

    // Model: direction as -1/+1 per axis, positions as plain ints
    int m_st, m_cnt, m_x, m_y, m_dx, m_dy, m_score;
    bit m_hit, m_miss;
    logic [29:0] o_vec;
    int extra;

    pong_ball_ctrl dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .serve(serve),
        .paddle_vpos(paddle_vpos), .ball_hpos(ball_hpos),
        .ball_vpos(ball_vpos), .state(state), .hit(hit),
        .miss(miss), .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [29:0] exp_vec();
        return {2'(m_st), 9'(m_x), 9'(m_y), m_hit, m_miss, 8'(m_score)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_x = CX; m_y = CY;
        m_dx = -1; m_dy = 1; m_score = 0; m_hit = 0; m_miss = 0;
    endtask

    task automatic model_tick();
        int nx, ny;
        bit left, on_pad;
        m_hit = 0;
        m_miss = 0;
        case (m_st)
            1: begin
                m_cnt++;
                if (m_cnt == SF) m_st = 2;
            end
            2: begin
                nx = m_x + 2 * m_dx;
                ny = m_y + 2 * m_dy;
                left = (nx < 0);
                on_pad = (m_y + 4 > int'(paddle_vpos))
                      && (m_y < int'(paddle_vpos) + 32);
                if (left && PADDLE_EN && !on_pad) begin
                    m_miss = 1;
                    m_score = (m_score + 1) % 256;
                    m_st = 3;
                end else begin
                    if (nx < 0 || nx > XMAX) begin
                        nx = (nx < 0) ? 0 : XMAX;
                        m_dx = -m_dx;
                        m_hit = 1;
                    end
                    if (ny < 0 || ny > YMAX) begin
                        ny = (ny < 0) ? 0 : YMAX;
                        m_dy = -m_dy;
                        m_hit = 1;
                    end
                    m_x = nx;
                    m_y = ny;
                end
            end
            3: begin
                m_st = 1; m_cnt = 0; m_x = CX; m_y = CY; m_dx = -1;
            end
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        vsync = 1'b0;
        serve = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One vsync pulse; samples outputs one cycle after the tick edge
    task automatic do_frame(input bit with_serve);
        int hi, lo;
        vsync = 1'b1;
        serve = with_serve;
        @(negedge clk);
        serve = 1'b0;
        if (with_serve && m_st == 0) begin
            m_st = 1; m_cnt = 0; m_hit = 0; m_miss = 0;
        end else begin
            model_tick();
        end
        o_vec = {state, ball_hpos, ball_vpos, hit, miss, score};
        extra = 0;
        hi = $urandom_range(0, 2);
        lo = $urandom_range(2, 4);
        repeat (hi) begin
            @(negedge clk);
            if (hit || miss) extra++;
        end
        vsync = 1'b0;
        repeat (lo) begin
            @(negedge clk);
            if (hit || miss) extra++;
        end
    endtask

    task automatic start_play();
        apply_reset();
        do_frame(1'b0);
        do_frame(1'b1);
        repeat (SF) do_frame(1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({state, ball_hpos, ball_vpos, hit, miss, score}
            !== {2'd0, 9'd128, 9'd120, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset: got st=%0d pos=(%0d,%0d) hit=%b miss=%b score=%0d want 0 (128,120) 0 0 0",
                     state, ball_hpos, ball_vpos, hit, miss, score);
        end
    endtask

    task automatic test_idle();
        for (int i = 1; i <= 10; i++) begin
            paddle_vpos = 9'($urandom_range(0, 239));
            do_frame(1'b0);
            total++;
            if (o_vec !== exp_vec() || o_vec[29:10] !== {2'd0, 9'd128, 9'd120}) begin
                bad++;
                $display("FAIL idle f%0d: got %h want %h", i, o_vec, exp_vec());
            end
        end
    endtask

    task automatic test_serve();
        logic [1:0] want_st;
        do_frame(1'b1);
        total++;
        if (o_vec !== exp_vec() || o_vec[29:28] !== 2'd1) begin
            bad++;
            $display("FAIL serve_start: got %h want %h", o_vec, exp_vec());
        end
        for (int i = 1; i <= SF; i++) begin
            do_frame(1'b0);
            want_st = (i < SF) ? 2'd1 : 2'd2;
            total++;
            if (o_vec !== exp_vec() || o_vec[29:28] !== want_st) begin
                bad++;
                $display("FAIL serve tick%0d: got %h want %h st %0d", i, o_vec, exp_vec(), want_st);
            end
        end
        do_frame(1'b0);
        total++;
        if (o_vec[27:10] !== {9'd126, 9'd122} || o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL first_move: got (%0d,%0d) want (126,122)", o_vec[27:19], o_vec[18:10]);
        end
    endtask

    task automatic test_play_bounce();
        for (int n = 2; n <= 59; n++) begin
            do_frame(1'b0);
            total++;
            if (o_vec !== exp_vec()) begin
                bad++;
                $display("FAIL play tick%0d: got %h want %h", n, o_vec, exp_vec());
            end
            if (n == 58) begin
                total++;
                if (o_vec[18:10] !== 9'd236 || o_vec[9] !== 1'b0) begin
                    bad++;
                    $display("FAIL bottom_approach: got y=%0d hit=%b want 236 0", o_vec[18:10], o_vec[9]);
                end
            end
            if (n == 59) begin
                total++;
                if (o_vec[18:10] !== 9'd236 || o_vec[9] !== 1'b1 || extra !== 0) begin
                    bad++;
                    $display("FAIL bottom_bounce: got y=%0d hit=%b extra=%0d want 236 1 0",
                             o_vec[18:10], o_vec[9], extra);
                end
            end
        end
    endtask

    task automatic test_left_wall();
        for (int n = 60; n <= 64; n++) begin
            do_frame(1'b0);
            total++;
            if (o_vec !== exp_vec()) begin
                bad++;
                $display("FAIL left tick%0d: got %h want %h", n, o_vec, exp_vec());
            end
        end
        total++;
        if (o_vec[27:10] !== {9'd0, 9'd226}) begin
            bad++;
            $display("FAIL left_approach: got (%0d,%0d) want (0,226)", o_vec[27:19], o_vec[18:10]);
        end
        paddle_vpos = 9'd210;
        do_frame(1'b0);
        total++;
        if (o_vec !== exp_vec() || o_vec[27:19] !== 9'd0 || o_vec[9:8] !== 2'b10
            || extra !== 0) begin
            bad++;
            $display("FAIL left_hit: got %h extra=%0d want %h", o_vec, extra, exp_vec());
        end
        do_frame(1'b0);
        total++;
        if (o_vec !== exp_vec() || o_vec[27:19] !== 9'd2) begin
            bad++;
            $display("FAIL left_rebound: got x=%0d want 2", o_vec[27:19]);
        end
    endtask

`ifdef PONG_PADDLE_EN
    task automatic test_miss();
        start_play();
        paddle_vpos = 9'd0;
        for (int n = 1; n <= 65; n++) do_frame(1'b0);
        total++;
        if (o_vec[29:28] !== 2'd3 || o_vec[8] !== 1'b1 || o_vec[7:0] !== 8'd1
            || extra !== 0 || o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL miss_event: got %h extra=%0d want %h", o_vec, extra, exp_vec());
        end
        do_frame(1'b0);
        total++;
        if (o_vec[29:10] !== {2'd1, 9'd128, 9'd120} || o_vec !== exp_vec()) begin
            bad++;
            $display("FAIL miss_reserve: got %h want %h", o_vec, exp_vec());
        end
    endtask
`endif

    task automatic test_async_reset();
        start_play();
        repeat (5) do_frame(1'b0);
        total++;
        if (o_vec !== exp_vec() || o_vec[29:28] !== 2'd2) begin
            bad++;
            $display("FAIL pre_reset: got %h want %h", o_vec, exp_vec());
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({state, ball_hpos, ball_vpos, hit, miss, score}
            !== {2'd0, 9'd128, 9'd120, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL async_reset: got st=%0d pos=(%0d,%0d) hit=%b miss=%b score=%0d",
                     state, ball_hpos, ball_vpos, hit, miss, score);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_random();
        int misses = 0;
        bit sv;
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            paddle_vpos = 9'($urandom_range(0, 239));
            sv = (m_st == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            do_frame(sv);
            if (o_vec[8]) misses++;
            total++;
            if (o_vec !== exp_vec() || extra !== 0) begin
                bad++;
                $display("FAIL random f%0d: got %h extra=%0d want %h", i, o_vec, extra, exp_vec());
            end
            total++;
            if (o_vec[27:19] > 9'd252 || o_vec[18:10] > 9'd236) begin
                bad++;
                $display("FAIL bounds f%0d: got (%0d,%0d) want within (252,236)",
                         i, o_vec[27:19], o_vec[18:10]);
            end
        end
`ifndef PONG_PADDLE_EN
        total++;
        if (misses !== 0 || score !== 8'd0) begin
            bad++;
            $display("FAIL no_miss: got misses=%0d score=%0d want 0 0", misses, score);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_serve();
        test_play_bounce();
        test_left_wall();
`ifdef PONG_PADDLE_EN
        test_miss();
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
